// File: rtl/stc_pkg.sv
// Shared definitions for the sparse tensor core operand loaders and B-row buffer.
// Holds the loader FSM encoding and the default B-tile geometry.
package stc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } stc_state_e;

  localparam int STC_K      = 16;
  localparam int STC_DW_MEM = 512;
  localparam int STC_DW_IDX = 4;

endpackage

// File: rtl/stc_bloader.sv
// B-operand tile fetch engine: issues K row reads, writes the in-order responses
// into the B-row buffer, then presents the tile until the compute array releases it.
module stc_bloader
  import stc_pkg::*;
#(
  parameter int K       = STC_K,
  parameter int DW_MEM  = STC_DW_MEM,
  parameter int DW_IDX  = STC_DW_IDX,
  parameter int AW      = 32,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AW-1:0]     base_addr,
  input  logic [AW-1:0]     row_stride,
  output logic              busy,
  output logic              mem_req_valid,
  output logic [AW-1:0]     mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DW_MEM-1:0] mem_resp_data,
  output logic              buf_write_en,
  output logic [DW_IDX-1:0] buf_row,
  output logic [DW_MEM-1:0] buf_data,
  output logic              tile_valid,
  input  logic              tile_consume,
  output logic              proto_err
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam logic [DW_IDX:0] LP_K       = (DW_IDX + 1)'(K);
  localparam logic [DW_IDX:0] LP_CNT_ONE = (DW_IDX + 1)'(1);
  localparam logic [OW-1:0]   LP_MAX_OUT = OW'(MAX_OUT);
  localparam logic [OW-1:0]   LP_OUT_ONE = OW'(1);

  stc_state_e        r_state;
  logic [AW-1:0]     r_addr;
  logic [AW-1:0]     r_stride;
  logic [DW_IDX:0]   r_issued;
  logic [DW_IDX:0]   r_received;
  logic [OW-1:0]     r_outstanding;
  logic              r_buf_we;
  logic [DW_IDX-1:0] r_buf_row;
  logic [DW_MEM-1:0] r_buf_data;
  logic              r_proto_err;

  logic w_req_valid;
  logic w_req_fire;
  logic w_resp_ok;

  // Request valid depends only on registered state, so valid and address
  // cannot change until the handshake that consumes them.
  assign w_req_valid = (r_state == ST_FETCH) && (r_issued < LP_K) &&
                       (r_outstanding < LP_MAX_OUT);
  assign w_req_fire  = w_req_valid && mem_req_ready;
  assign w_resp_ok   = mem_resp_valid && (r_state == ST_FETCH) &&
                       (r_outstanding != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_stride      <= '0;
      r_issued      <= '0;
      r_received    <= '0;
      r_outstanding <= '0;
      r_buf_we      <= 1'b0;
      r_buf_row     <= '0;
      r_buf_data    <= '0;
      r_proto_err   <= 1'b0;
    end else begin
      r_buf_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr        <= base_addr;
            r_stride      <= row_stride;
            r_issued      <= '0;
            r_received    <= '0;
            r_outstanding <= '0;
            r_state       <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (w_req_fire) begin
            r_issued <= r_issued + LP_CNT_ONE;
            r_addr   <= r_addr + r_stride;
          end
          if (w_resp_ok) begin
            r_received <= r_received + LP_CNT_ONE;
            r_buf_we   <= 1'b1;
            r_buf_row  <= r_received[DW_IDX-1:0];
            r_buf_data <= mem_resp_data;
          end
          if (w_req_fire && !w_resp_ok) begin
            r_outstanding <= r_outstanding + LP_OUT_ONE;
          end else if (!w_req_fire && w_resp_ok) begin
            r_outstanding <= r_outstanding - LP_OUT_ONE;
          end
          // received reaches K in the cycle the last buffer write is presented
          if (r_received == LP_K) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (tile_consume) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (mem_resp_valid && !w_resp_ok) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign busy          = (r_state != ST_IDLE);
  assign tile_valid    = (r_state == ST_DONE);
  assign mem_req_valid = w_req_valid;
  assign mem_req_addr  = r_addr;
  assign buf_write_en  = r_buf_we;
  assign buf_row       = r_buf_row;
  assign buf_data      = r_buf_data;
  assign proto_err     = r_proto_err;

endmodule

// File: tb/tb_stc_bloader.sv
// Randomized bench for stc_bloader: a transaction-level memory and tile model
// predicts every output each cycle, with literal pins on addresses and timing.
module tb_stc_bloader;

  localparam int K       = 16;
  localparam int DW_MEM  = 512;
  localparam int DW_IDX  = 4;
  localparam int AW      = 32;
  localparam int MAX_OUT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [AW-1:0]     row_stride;
  logic              busy;
  logic              mem_req_valid;
  logic [AW-1:0]     mem_req_addr;
  logic              mem_req_ready;
  logic              mem_resp_valid;
  logic [DW_MEM-1:0] mem_resp_data;
  logic              buf_write_en;
  logic [DW_IDX-1:0] buf_row;
  logic [DW_MEM-1:0] buf_data;
  logic              tile_valid;
  logic              tile_consume;
  logic              proto_err;

  always #5 clk = ~clk;

  stc_bloader #(
    .K(K), .DW_MEM(DW_MEM), .DW_IDX(DW_IDX), .AW(AW), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .base_addr(base_addr),
    .row_stride(row_stride),
    .busy(busy),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data),
    .buf_write_en(buf_write_en),
    .buf_row(buf_row),
    .buf_data(buf_data),
    .tile_valid(tile_valid),
    .tile_consume(tile_consume),
    .proto_err(proto_err)
  );

  typedef struct {
    int                due;
    logic [DW_MEM-1:0] data;
  } resp_t;

  resp_t         memQ[$];
  logic [AW-1:0] reqLog[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lastDue = 0;
  int latMin = 1;
  int latMax = 1;
  int readyPct = 100;

  // Tile model: phase 0 idle, 1 fetching, 2 tile resident
  int                mPhase = 0;
  int                mIss = 0;
  int                mRcv = 0;
  int                mWrow = 0;
  bit                mWpend = 1'b0;
  bit                mPerr = 1'b0;
  logic [AW-1:0]     mBase = '0;
  logic [AW-1:0]     mStride = '0;
  logic [DW_MEM-1:0] mWdata = '0;

  int lastRespCyc = -1;
  int tileRiseCyc = -1;
  int obsOut = 0;
  int maxObs = 0;

  task automatic checkOutput(input string name, input logic [DW_MEM-1:0] act,
                             input logic [DW_MEM-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW_MEM-1:0] randRow();
    logic [DW_MEM-1:0] v;
    v = '0;
    for (int i = 0; i < DW_MEM / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One clock cycle: check outputs against the model, drive inputs, advance the model
  task automatic applyStimulus(input bit iStart, input bit iConsume, input bit iSpur,
                               input bit iReset);
    bit                expValid;
    bit                hs;
    bit                acc;
    bit                respV;
    bit                lastRowShown;
    int                outs;
    int                due;
    logic [AW-1:0]     addrExp;
    logic [DW_MEM-1:0] rdata;
    resp_t             r;

    @(negedge clk);
    outs     = mIss - mRcv;
    expValid = (mPhase == 1) && (mIss < K) && (outs < MAX_OUT);
    addrExp  = mBase + mStride * AW'(mIss);
    checkOutput("busy", busy, mPhase != 0);
    checkOutput("req_valid", mem_req_valid, expValid);
    if (expValid) checkOutput("req_addr", mem_req_addr, addrExp);
    checkOutput("buf_we", buf_write_en, mWpend);
    if (mWpend) begin
      checkOutput("buf_row", buf_row, mWrow);
      checkOutput("buf_data", buf_data, mWdata);
    end
    checkOutput("tile_valid", tile_valid, mPhase == 2);
    checkOutput("proto_err", proto_err, mPerr);
    if (tile_valid && tileRiseCyc < 0) tileRiseCyc = cyc;

    rdata = '0;
    respV = 1'b0;
    if (memQ.size() > 0 && memQ[0].due <= cyc) begin
      r     = memQ.pop_front();
      respV = 1'b1;
      rdata = r.data;
    end else if (iSpur) begin
      respV = 1'b1;
      rdata = randRow();
    end
    reset          = iReset;
    start          = iStart;
    tile_consume   = iConsume;
    mem_req_ready  = ($urandom_range(99) < readyPct);
    mem_resp_valid = respV;
    mem_resp_data  = rdata;

    if (mem_req_valid && mem_req_ready) begin
      obsOut++;
      reqLog.push_back(mem_req_addr);
    end
    if (respV && obsOut > 0) obsOut--;
    if (obsOut > maxObs) maxObs = obsOut;

    hs           = expValid && mem_req_ready;
    acc          = respV && (mPhase == 1) && (outs > 0);
    lastRowShown = (mPhase == 1) && mWpend && (mWrow == K - 1);
    if (hs) begin
      due = cyc + $urandom_range(latMax, latMin);
      if (due <= lastDue) due = lastDue + 1;
      lastDue = due;
      r.due   = due;
      r.data  = randRow();
      memQ.push_back(r);
      mIss++;
    end
    mWpend = acc;
    if (acc) begin
      mWrow       = mRcv;
      mWdata      = rdata;
      mRcv++;
      lastRespCyc = cyc;
    end else if (respV) begin
      mPerr = 1'b1;
    end
    if (mPhase == 0 && iStart) begin
      mPhase  = 1;
      mIss    = 0;
      mRcv    = 0;
      mBase   = base_addr;
      mStride = row_stride;
    end else if (lastRowShown) begin
      mPhase = 2;
    end else if (mPhase == 2 && iConsume) begin
      mPhase = 0;
    end
    if (iReset) begin
      mPhase  = 0;
      mIss    = 0;
      mRcv    = 0;
      mWpend  = 1'b0;
      mWrow   = 0;
      mWdata  = '0;
      mPerr   = 1'b0;
      mBase   = '0;
      mStride = '0;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runToDone(input int budget);
    int n;
    n = 0;
    while (mPhase != 2 && n < budget) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    checkOutput("done_timeout", tile_valid, 1'b1);
  endtask

  task automatic drainMemory(input int budget);
    int n;
    n = 0;
    while (memQ.size() > 0 && n < budget) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    checkOutput("drain_timeout", memQ.size(), 0);
  endtask

  task automatic pinResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_req_valid"}, mem_req_valid, 1'b0);
    checkOutput({tag, "_req_addr"}, mem_req_addr, 0);
    checkOutput({tag, "_buf_we"}, buf_write_en, 1'b0);
    checkOutput({tag, "_buf_row"}, buf_row, 0);
    checkOutput({tag, "_buf_data"}, buf_data, 0);
    checkOutput({tag, "_tile_valid"}, tile_valid, 1'b0);
    checkOutput({tag, "_proto_err"}, proto_err, 1'b0);
  endtask

  task automatic startTile(input logic [AW-1:0] base, input logic [AW-1:0] stride);
    base_addr  = base;
    row_stride = stride;
    reqLog.delete();
    tileRiseCyc = -1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    reset          = 1'b1;
    start          = 1'b0;
    base_addr      = '0;
    row_stride     = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    tile_consume   = 1'b0;

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    pinResetOutputs("reset");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Basic load with fixed latency
    latMin = 3; latMax = 3; readyPct = 100;
    startTile(32'h0000_1000, 32'h0000_0040);
    runToDone(200);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_req_count", reqLog.size(), K);
    checkOutput("t1_addr0", reqLog[0], 32'h0000_1000);
    checkOutput("t1_addr1", reqLog[1], 32'h0000_1040);
    checkOutput("t1_addr15", reqLog[15], 32'h0000_13C0);
    checkOutput("t1_tile_latency", tileRiseCyc - lastRespCyc, 2);

    // Release, restart next cycle, backpressure with long latency, stray start
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    latMin = 20; latMax = 20; readyPct = 50;
    obsOut = 0; maxObs = 0;
    startTile($urandom, $urandom & 32'h0000_0FC0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    base_addr = 32'hDEAD_0000;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runToDone(2000);
    checkOutput("t3_req_count", reqLog.size(), K);
    checkOutput("t2_inflight_peak", maxObs, MAX_OUT);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Spurious response in IDLE, then a zero-stride tile with the error still sticky
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t4_perr_set", proto_err, 1'b1);
    checkOutput("t4_no_write", buf_write_en, 1'b0);
    latMin = 1; latMax = 8; readyPct = 70;
    startTile(32'h0004_2000, 32'h0);
    runToDone(1000);
    checkOutput("t4_zero_stride_first", reqLog[0], 32'h0004_2000);
    checkOutput("t4_zero_stride_last", reqLog[15], 32'h0004_2000);
    checkOutput("t4_perr_sticky", proto_err, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_perr_cleared", proto_err, 1'b0);

    // Reset mid-fetch after five responses
    latMin = 6; latMax = 10; readyPct = 100;
    startTile(32'h8000_0000, 32'h0000_0080);
    n = 0;
    while (mRcv < 5 && n < 200) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    checkOutput("t5_still_busy", busy, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    pinResetOutputs("t5_reset");
    drainMemory(200);
    checkOutput("t5_inflight_perr", proto_err, 1'b1);
    latMin = 1; latMax = 5;
    startTile(32'h0000_0100, 32'h0000_0200);
    runToDone(1000);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

    // Address wrap
    latMin = 1; latMax = 4; readyPct = 100;
    startTile(32'hFFFF_FFC0, 32'h0000_0040);
    runToDone(500);
    checkOutput("t6_addr0", reqLog[0], 32'hFFFF_FFC0);
    checkOutput("t6_addr1_wrap", reqLog[1], 32'h0000_0000);
    checkOutput("t6_addr2", reqLog[2], 32'h0000_0040);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

    // Random tiles with random latency, readiness and release delay
    for (int t = 0; t < 4; t++) begin
      latMin = 1; latMax = $urandom_range(24, 1); readyPct = $urandom_range(100, 30);
      startTile($urandom, ($urandom_range(3) == 0) ? 32'h0 : $urandom);
      runToDone(3000);
      for (int i = 0; i < int'($urandom_range(3)); i++)
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
